// File: rtl/sr_mon_pkg.sv
// rtl/sr_mon_pkg.sv - shared FSM type and SR command codes for the SR flop monitor
package sr_mon_pkg;

  typedef enum logic [1:0] {
    UNKNOWN = 2'b00,
    TRACK   = 2'b01,
    FAULT   = 2'b10
  } mon_state_t;

  localparam logic [1:0] SR_HOLD   = 2'b00;
  localparam logic [1:0] SR_RST    = 2'b01;
  localparam logic [1:0] SR_SET    = 2'b10;
  localparam logic [1:0] SR_FORBID = 2'b11;

endpackage

// File: rtl/sr_mon_sat_cnt.sv
// rtl/sr_mon_sat_cnt.sv - saturating event counter with synchronous clear
module sr_mon_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sr_ff_monitor.sv
// rtl/sr_ff_monitor.sv - passive checker tracking a clocked SR flop against a reference model
module sr_ff_monitor
  import sr_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Q_bar,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic             forbidden,
  output logic             err_sticky,
  output logic [CNT_W-1:0] cnt_set,
  output logic [CNT_W-1:0] cnt_reset,
  output logic [CNT_W-1:0] cnt_hold,
  output logic [CNT_W-1:0] cnt_forbid,
  output logic [CNT_W-1:0] cnt_mismatch
);

  mon_state_t state_q;
  logic       q_model_q;
  logic       exp_valid_q;
  logic       mismatch_q;
  logic       forbidden_q;
  logic       err_q;

  logic [1:0] sr;
  logic       sample;
  logic       mis_now;
  logic       forb_now;

  assign sr       = {S, R};
  assign sample   = en && !clr;
  // Q observed now reflects the command sampled one edge earlier, held in q_model_q.
  assign mis_now  = sample && exp_valid_q && (state_q != FAULT) &&
                    ((Q != q_model_q) || (Q_bar == Q));
  assign forb_now = sample && (sr == SR_FORBID);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNKNOWN;
      q_model_q   <= 1'b0;
      exp_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      forbidden_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mismatch_q  <= mis_now;
      forbidden_q <= forb_now;
      if (clr) begin
        state_q     <= UNKNOWN;
        q_model_q   <= 1'b0;
        exp_valid_q <= 1'b0;
        err_q       <= 1'b0;
      end else if (en) begin
        err_q <= err_q | mis_now;
        case (sr)
          SR_SET: begin
            q_model_q   <= 1'b1;
            exp_valid_q <= 1'b1;
          end
          SR_RST: begin
            q_model_q   <= 1'b0;
            exp_valid_q <= 1'b1;
          end
          SR_FORBID: exp_valid_q <= 1'b0;
          default:   ;
        endcase
        case (state_q)
          UNKNOWN: if ((sr == SR_SET) || (sr == SR_RST)) state_q <= TRACK;
          TRACK: begin
            // A real mismatch outranks a forbidden command seen on the same edge.
            if (mis_now && STOP_ON_ERR) state_q <= FAULT;
            else if (forb_now)          state_q <= UNKNOWN;
          end
          default: ;
        endcase
      end
    end
  end

  assign state      = state_q;
  assign mismatch   = mismatch_q;
  assign forbidden  = forbidden_q;
  assign err_sticky = err_q;

  sr_mon_sat_cnt #(.W(CNT_W)) u_cnt_set (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(sample && (sr == SR_SET)), .cnt(cnt_set)
  );

  sr_mon_sat_cnt #(.W(CNT_W)) u_cnt_reset (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(sample && (sr == SR_RST)), .cnt(cnt_reset)
  );

  sr_mon_sat_cnt #(.W(CNT_W)) u_cnt_hold (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(sample && (sr == SR_HOLD)), .cnt(cnt_hold)
  );

  sr_mon_sat_cnt #(.W(CNT_W)) u_cnt_forbid (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(forb_now), .cnt(cnt_forbid)
  );

  sr_mon_sat_cnt #(.W(CNT_W)) u_cnt_mismatch (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(mis_now), .cnt(cnt_mismatch)
  );

endmodule
